// File: rtl/l5_accum_ctrl_if.sv
// Streaming handshake bundle for l5_accum_ctrl: activation input stream and neuron result output.
interface l5_accum_ctrl_if;
    logic               in_valid;
    logic signed [17:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic signed [17:0] out_data;
    logic [3:0]         out_idx;
    logic               out_ready;

    // Producer/consumer side (testbench or upstream/downstream logic).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    // Accumulator controller side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/l5_accum_ctrl.sv
// Final-layer accumulate controller: buffers one activation vector, then for each output neuron
// streams the vector chunk by chunk through an external 32-lane multiplier-adder, accumulates the
// partial dot products, shifts, adds the bias, saturates to 18 bits and hands out the result.
module l5_accum_ctrl #(
    parameter int unsigned NUM_CHUNKS = 4,
    parameter int unsigned NUM_OUT    = 10,
    parameter int unsigned SHIFT      = 8
) (
    input  logic                clk,
    input  logic                rst,
    l5_accum_ctrl_if.slave      bus,
    output logic [31:0][17:0]   mac_din,
    output logic [5:0]          w_addr,
    input  logic signed [35:0]  mac_dout,
    input  logic signed [17:0]  bias_in
);

    localparam int unsigned        CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0]      LastChunk  = CW'(NUM_CHUNKS - 1);
    localparam logic [3:0]         LastNeuron = 4'(NUM_OUT - 1);
    localparam logic signed [17:0] SatMax     = 18'sh1FFFF;
    localparam logic signed [17:0] SatMin     = 18'sh20000;

    typedef enum logic [1:0] {StLoad, StMac, StDrain, StOut} state_e;

    state_e                           state_q;
    logic [4:0]                       lane_q;
    logic [CW-1:0]                    lchunk_q;
    logic [CW-1:0]                    c_q;
    logic [3:0]                       n_q;
    logic                             pend_q;   // a chunk was issued last cycle; mac_dout is live
    logic                             first_q;  // that chunk was chunk 0, so load instead of add
    logic signed [39:0]               acc_q;
    logic [31:0][17:0]                mac_din_q;
    logic                             out_valid_q;
    logic signed [17:0]               out_data_q;
    logic [NUM_CHUNKS-1:0][31:0][17:0] buf_q;

    logic signed [39:0] acc_sum;
    logic signed [39:0] acc_shift;
    logic signed [40:0] biased;
    logic signed [17:0] sat_val;

    assign bus.in_ready  = (state_q == StLoad) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = n_q;
    assign mac_din       = mac_din_q;

    // Weight ROM address for the chunk being issued; parked at zero outside MAC.
    always_comb begin
        w_addr = '0;
        if (state_q == StMac) begin
            w_addr = 6'(n_q) * 6'(NUM_CHUNKS) + 6'(c_q);
        end
    end

    // Running sum including the partial product arriving this cycle, plus the final scaling.
    always_comb begin
        acc_sum   = first_q ? 40'(mac_dout) : acc_q + 40'(mac_dout);
        acc_shift = acc_sum >>> SHIFT;
        biased    = 41'(acc_shift) + 41'(bias_in);
        if (biased > 41'sd131071) begin
            sat_val = SatMax;
        end else if (biased < -41'sd131072) begin
            sat_val = SatMin;
        end else begin
            sat_val = biased[17:0];
        end
    end

    // Activation buffer; written only by accepted words in LOAD, never reset.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StLoad) && bus.in_valid) begin
            buf_q[lchunk_q][lane_q] <= bus.in_data;
        end
    end

    // Main control FSM with registered datapath outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            lane_q      <= '0;
            lchunk_q    <= '0;
            c_q         <= '0;
            n_q         <= '0;
            pend_q      <= 1'b0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            mac_din_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pend_q  <= (state_q == StMac);
            first_q <= (state_q == StMac) && (c_q == '0);
            if (pend_q) begin
                acc_q <= acc_sum;
            end

            unique case (state_q)
                StLoad: begin
                    if (bus.in_valid) begin
                        lane_q <= lane_q + 5'd1;
                        if (lane_q == 5'd31) begin
                            if (lchunk_q == LastChunk) begin
                                lchunk_q <= '0;
                                c_q      <= '0;
                                n_q      <= '0;
                                state_q  <= StMac;
                            end else begin
                                lchunk_q <= lchunk_q + CW'(1);
                            end
                        end
                    end
                end
                StMac: begin
                    mac_din_q <= buf_q[c_q];
                    if (c_q == LastChunk) begin
                        c_q     <= '0;
                        state_q <= StDrain;
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                StDrain: begin
                    out_data_q  <= sat_val;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        c_q         <= '0;
                        if (n_q == LastNeuron) begin
                            n_q      <= '0;
                            lane_q   <= '0;
                            lchunk_q <= '0;
                            state_q  <= StLoad;
                        end else begin
                            n_q     <= n_q + 4'd1;
                            state_q <= StMac;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_l5_accum_ctrl.sv
// Scoreboard bench for l5_accum_ctrl: emulates the weight and bias ROMs and the multiplier-adder,
// predicts every neuron result from a plain dot-product model, and checks results, hold behaviour,
// latency and reset recovery from an independent monitor process.
module tb_l5_accum_ctrl;

    localparam int NC = 4;
    localparam int NO = 10;
    localparam int SH = 8;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [31:0][17:0]   mac_din;
    logic [5:0]          w_addr;
    logic signed [35:0]  mac_dout;
    logic signed [17:0]  bias_in;

    l5_accum_ctrl_if bus ();

    l5_accum_ctrl #(
        .NUM_CHUNKS (NC),
        .NUM_OUT    (NO),
        .SHIFT      (SH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mac_din  (mac_din),
        .w_addr   (w_addr),
        .mac_dout (mac_dout),
        .bias_in  (bias_in)
    );

    int   wrom [40][32];
    int   brom [10];
    int   acts [128];
    exp_t exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;

    logic signed [17:0] w_q [32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous weight ROM: data for w_addr appears one cycle later.
    always @(posedge clk) begin
        for (int l = 0; l < 32; l++) begin
            w_q[l] <= (w_addr < 6'd40) ? 18'(wrom[w_addr][l]) : 18'sd0;
        end
    end

    // Combinational 32-lane multiplier-adder.
    always_comb begin
        longint s;
        s = 0;
        for (int l = 0; l < 32; l++) begin
            s = s + longint'($signed(mac_din[l])) * longint'(w_q[l]);
        end
        mac_dout = 36'(s);
    end

    always_comb begin
        bias_in = (bus.out_idx < 4'd10) ? 18'(brom[bus.out_idx]) : 18'sd0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full 128-term dot product per neuron, then shift, bias, clamp.
    task automatic push_expected();
        for (int n = 0; n < NO; n++) begin
            longint acc = 0;
            exp_t   e;
            for (int k = 0; k < 128; k++) begin
                acc += longint'(acts[k]) * longint'(wrom[n * NC + k / 32][k % 32]);
            end
            acc = acc >>> SH;
            acc = acc + longint'(brom[n]);
            if (acc > 131071) acc = 131071;
            if (acc < -131072) acc = -131072;
            e.idx  = n;
            e.data = int'(acc);
            exp_q.push_back(e);
        end
    endtask

    // Downstream ready: always, random, or hold off neuron 3 for seven cycles.
    initial begin
        int stall = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.out_valid && bus.out_idx == 4'd3 && stall < 7) begin
                        bus.out_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                    if (bus.out_idx != 4'd3) stall = 0;
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, hold stability, result latency, return-to-load.
    initial begin
        int   cyc = 0;
        int   trig = 0;
        bit   trig_set = 0;
        int   xfer = 0;
        bit   prev_valid = 0;
        bit   prev_hold = 0;
        int   hold_data = 0;
        int   hold_idx = 0;
        bit   after_last = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                trig_set   = 0;
                xfer       = 0;
                prev_valid = 0;
                prev_hold  = 0;
                after_last = 0;
            end else begin
                if (after_last) begin
                    chk("last_valid_drop", bus.out_valid, 0);
                    chk("last_in_ready", bus.in_ready, 1);
                    after_last = 0;
                end
                if (prev_hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, hold_data);
                    chk("hold_idx", bus.out_idx, hold_idx);
                end
                if (bus.out_valid) begin
                    chk("in_ready_busy", bus.in_ready, 0);
                    if (!prev_valid && trig_set) begin
                        chk("latency", cyc - trig, 6);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    xfer++;
                    if (xfer == 128) begin
                        xfer     = 0;
                        trig     = cyc;
                        trig_set = 1;
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_idx", bus.out_idx, e.idx);
                        chk("out_data", bus.out_data, e.data);
                    end
                    if (bus.out_idx == 4'(NO - 1)) begin
                        after_last = 1;
                        trig_set   = 0;
                    end else begin
                        trig = cyc;
                    end
                end
                prev_hold  = bus.out_valid && !bus.out_ready;
                hold_data  = int'(bus.out_data);
                hold_idx   = int'(bus.out_idx);
                prev_valid = bus.out_valid;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_mac_din_zero", (mac_din == '0) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random.
    task automatic load_vec(input int gap);
        int k = 0;
        int guard = 0;
        bit ph = 0;
        bit v;
        @(posedge clk);
        #1;
        while (k < 128 && guard < 2000) begin
            case (gap)
                1: begin v = ph; ph = !ph; end
                2: v = 1'($urandom_range(0, 1));
                default: v = 1'b1;
            endcase
            bus.in_valid = v;
            bus.in_data  = 18'(acts[k]);
            if (v && bus.in_ready) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 18'($urandom);
        if (k < 128) chk("load_timeout", k, 128);
    endtask

    task automatic wait_done(input bit junk);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            if (junk) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 18'($urandom);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (exp_q.size() != 0) chk("result_timeout", exp_q.size(), 0);
    endtask

    task automatic fill_uniform(input int a, input int w, input int b);
        for (int k = 0; k < 128; k++) acts[k] = a;
        for (int r = 0; r < 40; r++) for (int l = 0; l < 32; l++) wrom[r][l] = w;
        for (int n = 0; n < NO; n++) brom[n] = b;
    endtask

    task automatic fill_random();
        int amp = 1 << $urandom_range(6, 17);
        for (int k = 0; k < 128; k++) acts[k] = $urandom_range(0, 2 * amp - 1) - amp;
        for (int r = 0; r < 40; r++) for (int l = 0; l < 32; l++) wrom[r][l] = $urandom_range(0, 510) - 255;
        for (int n = 0; n < NO; n++) brom[n] = $urandom_range(0, 262143) - 131072;
    endtask

    initial begin
        int sel [10];
        int guard;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int r = 0; r < 40; r++) for (int l = 0; l < 32; l++) wrom[r][l] = 0;
        for (int n = 0; n < NO; n++) brom[n] = 0;
        do_reset();

        // 256 * 1 * 128 = 32768, >>> 8 = 128, minus 5.
        fill_uniform(256, 1, -5);
        push_expected();
        load_vec(0);
        wait_done(0);

        // Positive and negative saturation.
        fill_uniform(131071, 255, 0);
        push_expected();
        load_vec(0);
        wait_done(0);
        fill_uniform(-131072, 255, 0);
        push_expected();
        load_vec(0);
        wait_done(1);

        // Ramp data with one-hot weights; every-other-cycle valid.
        for (int k = 0; k < 128; k++) acts[k] = k;
        for (int r = 0; r < 40; r++) for (int l = 0; l < 32; l++) wrom[r][l] = 0;
        for (int n = 0; n < NO; n++) begin
            sel[n]  = $urandom_range(0, 127);
            brom[n] = 0;
            wrom[n * NC + sel[n] / 32][sel[n] % 32] = 256;
        end
        push_expected();
        load_vec(1);
        wait_done(0);

        // Hold off neuron 3 for seven cycles.
        rdy_mode = 2;
        fill_random();
        push_expected();
        load_vec(0);
        wait_done(0);

        // Random vectors with random valid and ready.
        rdy_mode = 1;
        for (int t = 0; t < 3; t++) begin
            fill_random();
            push_expected();
            load_vec(2);
            wait_done(1);
        end
        rdy_mode = 0;

        // Abort during neuron 2 MAC, then a clean reload must match the model.
        fill_random();
        push_expected();
        load_vec(0);
        guard = 0;
        while (!(bus.out_idx == 4'd2 && !bus.out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_neuron2", bus.out_idx, 2);
        do_reset();
        fill_random();
        push_expected();
        load_vec(0);
        wait_done(0);

        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l5_accum_ctrl.md
L5_ACCUM_CTRL -- requirements
Module: l5_accum_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 4, meaning 32-lane chunks per input vector (128 activations).
REQ-002 SHALL have parameter NUM_OUT, default 10, meaning output neurons.
REQ-003 SHALL have parameter SHIFT, default 8, meaning arithmetic right shift applied to the accumulator before bias add.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, activation word valid.
REQ-007 SHALL have port in_data, input, signed 18, activation word.
REQ-008 SHALL have port in_ready, output, 1, block accepts an activation.
REQ-009 SHALL have port mac_din, output, signed 18 x 32 lanes, chunk vector driven to the 32-lane multiplier-adder.
REQ-010 SHALL have port w_addr, output, 6, weight ROM address; the ROM returns weights to the multiplier-adder one cycle later.
REQ-011 SHALL have port mac_dout, input, signed 36, combinational dot product of mac_din and the ROM weights.
REQ-012 SHALL have port bias_in, input, signed 18, bias for neuron out_idx, from an asynchronous bias ROM.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_data, output, signed 18, neuron result.
REQ-015 SHALL have port out_idx, output, 4, neuron index of out_data.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-017 SHALL implement states LOAD, MAC, DRAIN, OUT.
REQ-018 LOAD: in_ready=1; a word transfers when in_valid&&in_ready; word k (0..127) SHALL be stored at chunk k[6:5], lane k[4:0]; in_valid low SHALL stall with no write.
REQ-019 Transfer of word 32*NUM_CHUNKS-1 SHALL move to MAC with neuron n=0, chunk c=0; in_ready=0 outside LOAD.
REQ-020 MAC: cycle for chunk c SHALL drive w_addr=n*NUM_CHUNKS+c combinationally and register buffer chunk c onto mac_din at the edge ending that cycle.
REQ-021 mac_dout for chunk c SHALL be sampled one cycle after that chunk's issue; c=0 loads the 40-bit signed accumulator, others add, sign-extended.
REQ-022 After issuing c=NUM_CHUNKS-1, SHALL go to DRAIN (one cycle, final accumulate), then OUT.
REQ-023 On entering OUT, SHALL register out_data=saturate18((acc>>>SHIFT)+bias_in), clamped to [-131072,131071], and assert out_valid.
REQ-024 out_idx SHALL equal n during MAC, DRAIN and OUT.
REQ-025 OUT: out_valid, out_data, out_idx SHALL hold stable until out_valid&&out_ready.
REQ-026 On OUT handshake with n<NUM_OUT-1: n<=n+1, c<=0, to MAC (next cycle issues chunk 0).
REQ-027 On OUT handshake with n=NUM_OUT-1: to LOAD, word count 0, out_valid 0 the next cycle.
REQ-028 Activation buffer SHALL NOT change outside LOAD; in_valid outside LOAD SHALL be ignored.
REQ-029 Per-neuron latency: NUM_CHUNKS+1 cycles from first MAC cycle to out_valid (5 by default).
REQ-030 w_addr SHALL be 0 outside MAC.

Reset
REQ-031 While rst=1 on an edge: state LOAD, word count 0, n=0, c=0, accumulator 0, mac_din 0, out_valid 0, out_data 0, out_idx 0; in_ready SHALL be 0 while rst=1 and 1 the first cycle after.
REQ-032 rst in any state, including mid-MAC or OUT, SHALL abort the operation; previously loaded words and partial sums SHALL NOT affect later results.
REQ-033 Buffer contents need not reset; every word is rewritten before use.

Verification
REQ-034 128 words of 1, all weights 1, bias 0, SHIFT=0 -> 10 results of 128, out_idx 0..9, each 5 cycles after MAC entry with out_ready=1.
REQ-035 All words 131071, all weights 255, bias 0, SHIFT=0 -> every out_data=131071; words -131072 with weights 255 -> -131072.
REQ-036 Words 256, weights 1, bias -5, SHIFT=8 -> out_data=123 (32768>>>8=128, minus 5).
REQ-037 out_ready low 7 cycles at neuron 3 -> out_valid, out_data, out_idx=3 stable for all 7; neuron 4 MAC starts the cycle after the handshake.
REQ-038 in_valid toggled every other cycle -> exactly 128 transfers, no lost/duplicated words (ramp data 0..127, one-hot weights pick the expected lane).
REQ-039 rst pulsed during neuron 2 MAC -> out_valid 0, in_ready 1 the cycle after rst falls; fresh 128-word load yields results equal to a clean run.
